sample_sequencer: RTL and testbench

- Sequences periodic sampling of the pin controllers and ADC channels that share the sample bus.
- On each sample-period tick, walks the enabled channels in ascending order, one at a time. For each channel it drives channel_select/output_sample, captures sample_data and pushes a timestamped record into the sample FIFO that feeds sample_collector/EBI.
- Configured over the scheduler's command bus, like pincontrol.

---
 rtl/sample_sequencer_if.sv | 34 +++
 rtl/sample_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_sample_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_sequencer_if.sv
// Command bus, shared sample bus, sample FIFO and status signals of the sample sequencer.
interface sample_sequencer_if;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned RW = 64;

  logic          cmd_bus_en;
  logic          cmd_bus_wr;
  logic [AW-1:0] cmd_bus_addr;
  logic [DW-1:0] cmd_bus_data;
  logic [DW-1:0] current_time;
  logic          output_sample;
  logic [CW-1:0] channel_select;
  logic [DW-1:0] sample_data;
  logic [RW-1:0] fifo_din;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          busy;
  logic          overflow;
  logic          overrun;

  modport master (
    input  cmd_bus_en, cmd_bus_wr, cmd_bus_addr, cmd_bus_data, current_time,
    input  sample_data, fifo_full,
    output output_sample, channel_select, fifo_din, fifo_wr_en, busy, overflow, overrun
  );

  modport slave (
    output cmd_bus_en, cmd_bus_wr, cmd_bus_addr, cmd_bus_data, current_time,
    output sample_data, fifo_full,
    input  output_sample, channel_select, fifo_din, fifo_wr_en, busy, overflow, overrun
  );
endinterface

// File: rtl/sample_sequencer.sv
// Periodic channel sampler: on each period tick, scans the enabled channels in ascending
// order and pushes {channel, timestamp, sample} records into the sample FIFO.
module sample_sequencer #(
  parameter int unsigned POSITION     = 240,
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned SETTLE       = 2
) (
  input  logic               clk,
  input  logic               rst,
  sample_sequencer_if.master bus_io
);

  localparam int unsigned IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned PW = 32;
  localparam int unsigned TW = 24;
  localparam int unsigned CW = 8;
  localparam int unsigned AW = 19;
  localparam int unsigned RW = 64;

  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_CHANNELS - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);
  localparam logic [PW-1:0] PERIOD_RST  = PW'(75);
  localparam logic [AW-1:0] ADDR_MASK   = AW'(POSITION);
  localparam logic [AW-1:0] ADDR_PERIOD = AW'(POSITION + 1);
  localparam logic [AW-1:0] ADDR_CTRL   = AW'(POSITION + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SCAN, S_SELECT, S_CAPTURE, S_PUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d, shadow_q, shadow_d;
  logic [PW-1:0]           period_q, period_d, act_period_q, act_period_d, cnt_q, cnt_d;
  logic                    run_q, run_d;
  logic [TW-1:0]           ts_q, ts_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic [RW-1:0]           din_q, din_d;
  logic                    wr_q, wr_d, os_q, os_d, busy_q, busy_d;
  logic                    ovf_q, ovf_d, ovr_q, ovr_d;
  logic                    wr_c, clr_c, tick_c, ovf_set_c, ovr_set_c;
  logic                    unused_time_c;

  assign unused_time_c = ^bus_io.current_time[PW-1:TW];

  // Command-bus register writes; period 0 is stored as 1, clear is a one-cycle strobe.
  always_comb begin
    wr_c     = bus_io.cmd_bus_en & bus_io.cmd_bus_wr;
    mask_d   = mask_q;
    period_d = period_q;
    run_d    = run_q;
    clr_c    = 1'b0;
    if (wr_c && bus_io.cmd_bus_addr == ADDR_MASK)
      mask_d = NUM_CHANNELS'(bus_io.cmd_bus_data);
    if (wr_c && bus_io.cmd_bus_addr == ADDR_PERIOD)
      period_d = (bus_io.cmd_bus_data == '0) ? PW'(1) : bus_io.cmd_bus_data;
    if (wr_c && bus_io.cmd_bus_addr == ADDR_CTRL) begin
      run_d = bus_io.cmd_bus_data[0];
      clr_c = bus_io.cmd_bus_data[1];
    end
  end

  // Period counter; a new period is picked up only at a wrap or while stopped.
  always_comb begin
    tick_c       = run_q && (cnt_q == act_period_q - PW'(1));
    cnt_d        = (!run_q || tick_c) ? '0 : cnt_q + PW'(1);
    act_period_d = (!run_q || tick_c) ? period_q : act_period_q;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    shadow_d  = shadow_q;
    ts_d      = ts_q;
    chan_d    = chan_q;
    din_d     = din_q;
    wr_d      = 1'b0;
    ovf_set_c = 1'b0;
    ovr_set_c = tick_c && (state_q inside {S_SCAN, S_SELECT, S_CAPTURE, S_PUSH});
    case (state_q)
      // A tick seen in the cycle run takes effect (period 1) starts a round as from WAIT.
      S_IDLE, S_WAIT: begin
        if (run_q) state_d = S_WAIT;
        if (tick_c) begin
          shadow_d = mask_q;
          ts_d     = bus_io.current_time[TW-1:0];
          if (mask_q != '0) begin
            idx_d   = '0;
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (shadow_q[idx_q]) begin
          chan_d   = CW'(idx_q);
          settle_d = '0;
          state_d  = S_SELECT;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_SELECT: begin
        if (settle_q == LAST_SETTLE) state_d = S_CAPTURE;
        else                         settle_d = settle_q + SW'(1);
      end
      S_CAPTURE: begin
        din_d   = {CW'(idx_q), ts_q, bus_io.sample_data};
        state_d = S_PUSH;
      end
      S_PUSH: begin
        if (bus_io.fifo_full) ovf_set_c = 1'b1;
        else                  wr_d      = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Stopping abandons the round immediately, including a pending push.
    if (!run_d) begin
      state_d   = S_IDLE;
      wr_d      = 1'b0;
      ovf_set_c = 1'b0;
    end
    os_d   = (state_d == S_SELECT);
    busy_d = state_d inside {S_SCAN, S_SELECT, S_CAPTURE, S_PUSH};
    ovf_d  = (ovf_q & ~clr_c) | ovf_set_c;
    ovr_d  = (ovr_q & ~clr_c) | ovr_set_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      settle_q     <= '0;
      mask_q       <= '0;
      shadow_q     <= '0;
      period_q     <= PERIOD_RST;
      act_period_q <= PERIOD_RST;
      cnt_q        <= '0;
      run_q        <= 1'b0;
      ts_q         <= '0;
      chan_q       <= '0;
      din_q        <= '0;
      wr_q         <= 1'b0;
      os_q         <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      period_q     <= period_d;
      act_period_q <= act_period_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      ts_q         <= ts_d;
      chan_q       <= chan_d;
      din_q        <= din_d;
      wr_q         <= wr_d;
      os_q         <= os_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus_io.output_sample  = os_q;
  assign bus_io.channel_select = chan_q;
  assign bus_io.fifo_din       = din_q;
  assign bus_io.fifo_wr_en     = wr_q;
  assign bus_io.busy           = busy_q;
  assign bus_io.overflow       = ovf_q;
  assign bus_io.overrun        = ovr_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: collects FIFO pushes and checks them against
// hand-computed channel/timestamp/sample records.
module tb_sample_sequencer;
  localparam int unsigned POS = 240;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] now_q = '0;
  logic [15:0] salt;
  logic [31:0] last_wr_t;
  logic [31:0] w;
  logic [63:0] r;
  logic [63:0] recs[$];
  int          os_lens[$];
  int          os_run = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  sample_sequencer_if bus_if ();

  sample_sequencer #(.POSITION(POS), .NUM_CHANNELS(16), .SETTLE(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) now_q <= now_q + 32'd1;

  assign bus_if.current_time = now_q;
  assign bus_if.sample_data  = {salt, 8'h00, bus_if.channel_select};

  // Record every push and the length of every output_sample pulse.
  always @(negedge clk) begin
    if (bus_if.fifo_wr_en) recs.push_back(bus_if.fifo_din);
    if (bus_if.output_sample) os_run++;
    else if (os_run > 0) begin
      os_lens.push_back(os_run);
      os_run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_rec(input int unsigned ch, input logic [31:0] ts);
    return {8'(ch), ts[23:0], salt, 8'h00, 8'(ch)};
  endfunction

  function automatic logic [63:0] get_rec(input int i);
    if (i < recs.size()) return recs[i];
    return '1;
  endfunction

  function automatic int get_os(input int i);
    if (i < os_lens.size()) return os_lens[i];
    return -1;
  endfunction

  task automatic cmd_write(input int unsigned off, input logic [31:0] data);
    @(negedge clk);
    bus_if.cmd_bus_en   = 1'b1;
    bus_if.cmd_bus_wr   = 1'b1;
    bus_if.cmd_bus_addr = 19'(POS + off);
    bus_if.cmd_bus_data = data;
    last_wr_t           = now_q;
    @(negedge clk);
    bus_if.cmd_bus_en   = 1'b0;
    bus_if.cmd_bus_wr   = 1'b0;
  endtask

  task automatic wait_recs(input int n, input int budget, input string tag);
    int k = 0;
    while (recs.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_eq({tag, "_arrived"}, 64'(recs.size() >= n), 64'(1));
    @(negedge clk);
  endtask

  task automatic wait_sel(input logic [7:0] ch, input int budget, input string tag);
    int  k = 0;
    logic hit = 1'b0;
    while (!hit && k < budget) begin
      @(negedge clk);
      hit = bus_if.output_sample && bus_if.channel_select == ch;
      k++;
    end
    check_eq({tag, "_selected"}, 64'(hit), 64'(1));
  endtask

  task automatic wait_level(input logic want_busy, input int budget, input string tag);
    int k = 0;
    while (bus_if.busy !== want_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_busy"}, 64'(bus_if.busy), 64'(want_busy));
  endtask

  task automatic wait_os_fall(input int budget, input string tag);
    int   k = 0;
    logic prev = bus_if.output_sample;
    logic fell = 1'b0;
    while (!fell && k < budget) begin
      @(negedge clk);
      fell = prev && !bus_if.output_sample;
      prev = bus_if.output_sample;
      k++;
    end
    check_eq({tag, "_os_fell"}, 64'(fell), 64'(1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_wr_en"},   64'(bus_if.fifo_wr_en),     64'(0));
    check_eq({tag, "_din"},     bus_if.fifo_din,            64'(0));
    check_eq({tag, "_os"},      64'(bus_if.output_sample),  64'(0));
    check_eq({tag, "_chan"},    64'(bus_if.channel_select), 64'(0));
    check_eq({tag, "_busy"},    64'(bus_if.busy),           64'(0));
    check_eq({tag, "_ovf"},     64'(bus_if.overflow),       64'(0));
    check_eq({tag, "_ovr"},     64'(bus_if.overrun),        64'(0));
  endtask

  task automatic clear_logs();
    @(posedge clk);
    recs.delete();
    os_lens.delete();
    @(negedge clk);
  endtask

  initial begin
    bus_if.cmd_bus_en   = 1'b0;
    bus_if.cmd_bus_wr   = 1'b0;
    bus_if.cmd_bus_addr = '0;
    bus_if.cmd_bus_data = '0;
    bus_if.fifo_full    = 1'b0;
    salt                = 16'h0000;
    rst                 = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Two channels per round, ticks every 100 cycles.
    salt = 16'h1111;
    cmd_write(0, 32'h5);
    cmd_write(1, 32'd100);
    cmd_write(2, 32'h1);
    w = last_wr_t;
    wait_recs(4, 450, "t1");
    check_eq("t1_rec0", get_rec(0), exp_rec(0, w + 32'd100));
    check_eq("t1_rec1", get_rec(1), exp_rec(2, w + 32'd100));
    check_eq("t1_rec2", get_rec(2), exp_rec(0, w + 32'd200));
    check_eq("t1_rec3", get_rec(3), exp_rec(2, w + 32'd200));
    for (int i = 0; i < 4; i++) check_eq($sformatf("t1_os_len%0d", i), 64'(get_os(i)), 64'(2));
    check_eq("t1_ovr", 64'(bus_if.overrun), 64'(0));
    check_eq("t1_ovf", 64'(bus_if.overflow), 64'(0));
    cmd_write(2, 32'h0);
    clear_logs();

    // All channels, period far shorter than a round: overrun, ticks dropped.
    salt = 16'h2222;
    cmd_write(0, 32'hFFFF);
    cmd_write(1, 32'd20);
    cmd_write(2, 32'h1);
    w = last_wr_t;
    wait_recs(32, 300, "t2");
    for (int i = 0; i < 32; i++) begin
      r = get_rec(i);
      check_eq($sformatf("t2_chan%0d", i), 64'(r[63:56]), 64'(i % 16));
    end
    check_eq("t2_rec0",  get_rec(0),  exp_rec(0, w + 32'd20));
    check_eq("t2_rec16", get_rec(16), exp_rec(0, w + 32'd120));
    check_eq("t2_ovr_set", 64'(bus_if.overrun), 64'(1));
    cmd_write(2, 32'h2);
    check_eq("t2_ovr_clr", 64'(bus_if.overrun), 64'(0));
    check_eq("t2_busy_off", 64'(bus_if.busy), 64'(0));
    clear_logs();

    // FIFO full during channel 3 push: record dropped, overflow sticky.
    salt = 16'h3333;
    cmd_write(0, 32'hF);
    cmd_write(1, 32'd100);
    cmd_write(2, 32'h1);
    w = last_wr_t;
    wait_sel(8'd3, 250, "t3");
    bus_if.fifo_full = 1'b1;
    wait_level(1'b0, 100, "t3_round_end");
    bus_if.fifo_full = 1'b0;
    wait_recs(7, 250, "t3");
    check_eq("t3_rec2", get_rec(2), exp_rec(2, w + 32'd100));
    check_eq("t3_rec3", get_rec(3), exp_rec(0, w + 32'd200));
    check_eq("t3_rec6", get_rec(6), exp_rec(3, w + 32'd200));
    check_eq("t3_ovf_set", 64'(bus_if.overflow), 64'(1));
    cmd_write(2, 32'h0);
    check_eq("t3_ovf_sticky", 64'(bus_if.overflow), 64'(1));
    cmd_write(2, 32'h2);
    check_eq("t3_ovf_clr", 64'(bus_if.overflow), 64'(0));
    clear_logs();

    // Mask rewritten mid-round only affects the next round.
    salt = 16'h4444;
    cmd_write(0, 32'hF0);
    cmd_write(2, 32'h1);
    w = last_wr_t;
    wait_level(1'b1, 200, "t4_round_start");
    cmd_write(0, 32'h1);
    wait_recs(5, 250, "t4");
    for (int i = 0; i < 4; i++) check_eq($sformatf("t4_rec%0d", i), get_rec(i), exp_rec(4 + i, w + 32'd100));
    check_eq("t4_rec4", get_rec(4), exp_rec(0, w + 32'd200));
    cmd_write(2, 32'h0);
    clear_logs();

    // Stop during SELECT of channel 5, then restart with the default period.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    salt = 16'h5555;
    cmd_write(0, 32'h21);
    cmd_write(2, 32'h1);
    w = last_wr_t;
    wait_sel(8'd5, 200, "t5");
    cmd_write(2, 32'h0);
    check_eq("t5_os_off", 64'(bus_if.output_sample), 64'(0));
    check_eq("t5_busy_off", 64'(bus_if.busy), 64'(0));
    repeat (20) @(negedge clk);
    check_eq("t5_no_extra_push", 64'(recs.size()), 64'(1));
    check_eq("t5_rec0", get_rec(0), exp_rec(0, w + 32'd75));
    clear_logs();
    cmd_write(2, 32'h1);
    w = last_wr_t;
    wait_recs(1, 150, "t5_restart");
    check_eq("t5_restart_rec0", get_rec(0), exp_rec(5 - 5, w + 32'd75));
    cmd_write(2, 32'h0);
    clear_logs();

    // Period 0 means a tick every cycle; then reset lands on a PUSH.
    salt = 16'h6666;
    cmd_write(0, 32'h1);
    cmd_write(1, 32'h0);
    cmd_write(2, 32'h1);
    w = last_wr_t;
    wait_recs(1, 50, "t6");
    check_eq("t6_rec0", get_rec(0), exp_rec(0, w + 32'd1));
    check_eq("t6_ovr_set", 64'(bus_if.overrun), 64'(1));
    wait_os_fall(100, "t6");
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("t6_rst");
    rst = 1'b0;
    clear_logs();
    cmd_write(0, 32'h1);
    cmd_write(2, 32'h1);
    w = last_wr_t;
    wait_recs(1, 150, "t6_after_rst");
    check_eq("t6_after_rst_rec0", get_rec(0), exp_rec(0, w + 32'd75));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
